pe_local_port: RTL and testbench

- Clocked network interface between a PE and its mesh router's local port.
- Ingress: consumes packets from the router local output, checks the destination, and sorts them by type into a filter FIFO and an ifmap FIFO. Each FIFO feeds its own PE operand stream.
- Egress: packetizes PE partial sums into 32-bit packets for the router local input.
- Sits directly downstream of the router's forward stage and upstream of its arbiter.

---
 rtl/pe_local_port.sv | 151 +++++++++++++++
 tb/tb_pe_local_port.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_local_port.sv
// Network interface between a PE and its router's local port: sorts ingress
// packets into filter/ifmap FIFOs and packetizes PE partial sums for egress.
module pe_local_port #(
    parameter logic [2:0]  ADDRX      = 3'd0,
    parameter logic [4:0]  ADDRY      = 5'd0,
    parameter logic [7:0]  PSUM_DST   = 8'h00,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] rx_pkt,
    output logic        filt_valid,
    input  logic        filt_ready,
    output logic [12:0] filt_data,
    output logic [7:0]  filt_src,
    output logic        ifm_valid,
    input  logic        ifm_ready,
    output logic [12:0] ifm_data,
    input  logic        psum_valid,
    output logic        psum_ready,
    input  logic [12:0] psum_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_pkt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DATA_W = 13;
    localparam int unsigned FENT_W = DATA_W + 8;

    logic [FENT_W-1:0] filt_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] ifm_mem_q  [FIFO_DEPTH];

    logic [PTR_W-1:0] filt_wptr_q, filt_wptr_d, filt_rptr_q, filt_rptr_d;
    logic [PTR_W-1:0] ifm_wptr_q, ifm_wptr_d, ifm_rptr_q, ifm_rptr_d;
    logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d, ifm_cnt_q, ifm_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             tx_valid_q, tx_valid_d;
    logic [31:0]      tx_pkt_q, tx_pkt_d;

    logic hit, filt_tgt, ifm_tgt, drop_tgt;
    logic filt_full, ifm_full, rx_fire;
    logic filt_push, filt_pop, ifm_push, ifm_pop, drop_acc, psum_acc;
    logic unused_rsvd;

    assign unused_rsvd = rx_pkt[31];

    // Ingress classification straight off the incoming packet
    assign hit      = (rx_pkt[28:21] == {ADDRY, ADDRX});
    assign filt_tgt = hit && (rx_pkt[30:29] == 2'b00);
    assign ifm_tgt  = hit && (rx_pkt[30:29] == 2'b01);
    assign drop_tgt = !filt_tgt && !ifm_tgt;

    // Full is judged on registered occupancy; a same-cycle pop does not free a slot
    assign filt_full = (filt_cnt_q == CNT_W'(FIFO_DEPTH));
    assign ifm_full  = (ifm_cnt_q == CNT_W'(FIFO_DEPTH));

    always_comb begin
        rx_ready = 1'b0;
        if (!rst) begin
            if (filt_tgt)     rx_ready = !filt_full;
            else if (ifm_tgt) rx_ready = !ifm_full;
            else              rx_ready = 1'b1;
        end
    end

    assign rx_fire    = rx_valid && rx_ready;
    assign filt_push  = rx_fire && filt_tgt;
    assign ifm_push   = rx_fire && ifm_tgt;
    assign drop_acc   = rx_fire && drop_tgt;
    assign filt_valid = (filt_cnt_q != '0);
    assign ifm_valid  = (ifm_cnt_q != '0);
    assign filt_pop   = filt_valid && filt_ready;
    assign ifm_pop    = ifm_valid && ifm_ready;
    assign psum_ready = !rst && (!tx_valid_q || tx_ready);
    assign psum_acc   = psum_valid && psum_ready;

    assign filt_data = filt_mem_q[filt_rptr_q][DATA_W-1:0];
    assign filt_src  = filt_mem_q[filt_rptr_q][FENT_W-1:DATA_W];
    assign ifm_data  = ifm_mem_q[ifm_rptr_q];
    assign tx_valid  = tx_valid_q;
    assign tx_pkt    = tx_pkt_q;
    assign err_cnt   = err_cnt_q;

    // Next-state for pointers, occupancy, drop counter and egress register
    always_comb begin
        filt_wptr_d = filt_wptr_q;
        filt_rptr_d = filt_rptr_q;
        filt_cnt_d  = filt_cnt_q;
        ifm_wptr_d  = ifm_wptr_q;
        ifm_rptr_d  = ifm_rptr_q;
        ifm_cnt_d   = ifm_cnt_q;
        err_cnt_d   = err_cnt_q;
        tx_valid_d  = tx_valid_q;
        tx_pkt_d    = tx_pkt_q;

        if (filt_push) filt_wptr_d = filt_wptr_q + PTR_W'(1);
        if (filt_pop)  filt_rptr_d = filt_rptr_q + PTR_W'(1);
        if (filt_push && !filt_pop)      filt_cnt_d = filt_cnt_q + CNT_W'(1);
        else if (!filt_push && filt_pop) filt_cnt_d = filt_cnt_q - CNT_W'(1);

        if (ifm_push) ifm_wptr_d = ifm_wptr_q + PTR_W'(1);
        if (ifm_pop)  ifm_rptr_d = ifm_rptr_q + PTR_W'(1);
        if (ifm_push && !ifm_pop)      ifm_cnt_d = ifm_cnt_q + CNT_W'(1);
        else if (!ifm_push && ifm_pop) ifm_cnt_d = ifm_cnt_q - CNT_W'(1);

        if (drop_acc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

        if (psum_acc) begin
            tx_valid_d = 1'b1;
            tx_pkt_d   = {1'b0, 2'b10, PSUM_DST, ADDRY, ADDRX, psum_data};
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_wptr_q <= '0;
            filt_rptr_q <= '0;
            filt_cnt_q  <= '0;
            ifm_wptr_q  <= '0;
            ifm_rptr_q  <= '0;
            ifm_cnt_q   <= '0;
            err_cnt_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_pkt_q    <= '0;
        end else begin
            filt_wptr_q <= filt_wptr_d;
            filt_rptr_q <= filt_rptr_d;
            filt_cnt_q  <= filt_cnt_d;
            ifm_wptr_q  <= ifm_wptr_d;
            ifm_rptr_q  <= ifm_rptr_d;
            ifm_cnt_q   <= ifm_cnt_d;
            err_cnt_q   <= err_cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_pkt_q    <= tx_pkt_d;
        end
    end

    // Storage arrays need no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (filt_push) filt_mem_q[filt_wptr_q] <= {rx_pkt[20:13], rx_pkt[12:0]};
        if (ifm_push)  ifm_mem_q[ifm_wptr_q]   <= rx_pkt[12:0];
    end

endmodule

// File: tb/tb_pe_local_port.sv
// Directed bench for pe_local_port with a queue-based reference model checked every cycle.
module tb_pe_local_port;

    localparam logic [2:0] AX = 3'd2;
    localparam logic [4:0] AY = 5'd13;
    localparam int         DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] rx_pkt = '0;
    logic        filt_valid;
    logic        filt_ready = 1'b0;
    logic [12:0] filt_data;
    logic [7:0]  filt_src;
    logic        ifm_valid;
    logic        ifm_ready = 1'b0;
    logic [12:0] ifm_data;
    logic        psum_valid = 1'b0;
    logic        psum_ready;
    logic [12:0] psum_data = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_pkt;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_pass = 0;

    pe_local_port #(
        .ADDRX(AX), .ADDRY(AY), .PSUM_DST(8'h00), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_pkt(rx_pkt),
        .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data), .filt_src(filt_src),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_pkt(tx_pkt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [4:0] y, input logic [2:0] x,
                                       input logic [7:0] src, input logic [12:0] d);
        return {1'b0, t, y, x, src, d};
    endfunction

    // Reference model: two bounded queues, a drop counter and one egress slot
    logic [20:0] fq[$];
    logic [12:0] iq[$];
    int          m_err = 0;
    logic        m_txv = 1'b0;
    logic [31:0] m_txp = '0;

    function automatic logic exp_rx_ready();
        logic h;
        if (rst) return 1'b0;
        h = (rx_pkt[28:21] == {AY, AX});
        if (h && rx_pkt[30:29] == 2'b00) return fq.size() < DEPTH;
        if (h && rx_pkt[30:29] == 2'b01) return iq.size() < DEPTH;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic acc, pf, pi, pa, h;
        if (rst) begin
            fq.delete();
            iq.delete();
            m_err = 0;
            m_txv = 1'b0;
            m_txp = '0;
        end else begin
            acc = rx_valid && exp_rx_ready();
            pf  = filt_ready && fq.size() > 0;
            pi  = ifm_ready && iq.size() > 0;
            pa  = psum_valid && (!m_txv || tx_ready);
            h   = (rx_pkt[28:21] == {AY, AX});
            if (pf) void'(fq.pop_front());
            if (pi) void'(iq.pop_front());
            if (acc) begin
                if (h && rx_pkt[30:29] == 2'b00)      fq.push_back(rx_pkt[20:0]);
                else if (h && rx_pkt[30:29] == 2'b01) iq.push_back(rx_pkt[12:0]);
                else if (m_err < 255)                 m_err++;
            end
            if (pa) begin
                m_txv = 1'b1;
                m_txp = {1'b0, 2'b10, 8'h00, AY, AX, psum_data};
            end else if (tx_ready) begin
                m_txv = 1'b0;
            end
        end
    end

    // Per-cycle comparison shortly after each rising edge
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            chk("rx_ready_rst", 32'(rx_ready), 32'(0));
        end else begin
            chk("rx_ready", 32'(rx_ready), 32'(exp_rx_ready()));
            chk("filt_valid", 32'(filt_valid), 32'(fq.size() > 0));
            if (fq.size() > 0) begin
                chk("filt_data", 32'(filt_data), 32'(fq[0][12:0]));
                chk("filt_src", 32'(filt_src), 32'(fq[0][20:13]));
            end
            chk("ifm_valid", 32'(ifm_valid), 32'(iq.size() > 0));
            if (iq.size() > 0) chk("ifm_data", 32'(ifm_data), 32'(iq[0]));
            chk("psum_ready", 32'(psum_ready), 32'(!m_txv || tx_ready));
            chk("tx_valid", 32'(tx_valid), 32'(m_txv));
            if (m_txv) chk("tx_pkt", tx_pkt, m_txp);
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
        end
    end

    task automatic send(input logic [31:0] p);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_pkt   = p;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_pkt   = '0;
    endtask

    task automatic pop_filt();
        @(negedge clk);
        filt_ready = 1'b1;
        @(negedge clk);
        filt_ready = 1'b0;
    endtask

    task automatic pop_ifm();
        @(negedge clk);
        ifm_ready = 1'b1;
        @(negedge clk);
        ifm_ready = 1'b0;
    endtask

    int beats;

    initial begin
        // Reset then idle
        #3;
        rx_valid = 1'b1;
        rx_pkt   = mk(2'b11, 5'd0, 3'd0, 8'h00, 13'd0);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'(0));
        chk("rst_tx_valid", 32'(tx_valid), 32'(0));
        chk("rst_filt_valid", 32'(filt_valid), 32'(0));
        chk("rst_err_cnt", 32'(err_cnt), 32'(0));
        #4;
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rx_ready", 32'(rx_ready), 32'(1));
        rx_pkt = '0;

        // Ingress sort
        send(mk(2'b00, 5'd13, 3'd2, 8'hFF, 13'd57));
        chk("sort_filt_valid", 32'(filt_valid), 32'(1));
        chk("sort_filt_data", 32'(filt_data), 32'd57);
        chk("sort_filt_src", 32'(filt_src), 32'hFF);
        chk("sort_ifm_valid", 32'(ifm_valid), 32'(0));
        pop_filt();
        send(mk(2'b01, 5'd13, 3'd2, 8'h11, 13'd1));
        chk("sort_ifm_data", 32'(ifm_data), 32'd1);
        chk("sort_filt_empty", 32'(filt_valid), 32'(0));
        pop_ifm();

        // Fill the filter FIFO and try one more
        for (int i = 1; i <= 4; i++) send(mk(2'b00, 5'd13, 3'd2, 8'(8'h20 + i), 13'(i)));
        @(negedge clk);
        rx_valid = 1'b1;
        rx_pkt   = mk(2'b00, 5'd13, 3'd2, 8'h25, 13'd5);
        #1;
        chk("full_rx_ready", 32'(rx_ready), 32'(0));
        @(negedge clk);
        rx_pkt = mk(2'b01, 5'd13, 3'd2, 8'h30, 13'd9);
        #1;
        chk("ifm_while_full", 32'(rx_ready), 32'(1));
        @(negedge clk);
        rx_valid = 1'b0;
        rx_pkt   = '0;
        chk("ifm_full_data", 32'(ifm_data), 32'd9);
        pop_ifm();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("fifo_order", 32'(filt_data), 32'(i));
            filt_ready = 1'b1;
        end
        @(negedge clk);
        filt_ready = 1'b0;
        chk("fifo_drained", 32'(filt_valid), 32'(0));

        // Pointer wrap
        for (int i = 5; i <= 8; i++) send(mk(2'b00, 5'd13, 3'd2, 8'h40, 13'(i)));
        for (int i = 5; i <= 8; i++) begin
            @(negedge clk);
            chk("wrap_order", 32'(filt_data), 32'(i));
            filt_ready = 1'b1;
        end
        @(negedge clk);
        filt_ready = 1'b0;

        // Simultaneous push and pop keeps a single entry
        send(mk(2'b00, 5'd13, 3'd2, 8'h50, 13'd10));
        @(negedge clk);
        rx_valid   = 1'b1;
        rx_pkt     = mk(2'b00, 5'd13, 3'd2, 8'h51, 13'd11);
        filt_ready = 1'b1;
        @(negedge clk);
        rx_valid   = 1'b0;
        rx_pkt     = '0;
        filt_ready = 1'b0;
        chk("pushpop_data", 32'(filt_data), 32'd11);
        pop_filt();
        chk("pushpop_empty", 32'(filt_valid), 32'(0));

        // Drops
        send(mk(2'b11, 5'd13, 3'd2, 8'h00, 13'd3));
        send(mk(2'b00, 5'd12, 3'd2, 8'h00, 13'd4));
        chk("drop_err2", 32'(err_cnt), 32'd2);
        chk("drop_no_filt", 32'(filt_valid), 32'(0));
        chk("drop_no_ifm", 32'(ifm_valid), 32'(0));
        @(negedge clk);
        rx_valid = 1'b1;
        rx_pkt   = mk(2'b10, 5'd13, 3'd2, 8'h00, 13'd0);
        repeat (300) @(negedge clk);
        rx_valid = 1'b0;
        rx_pkt   = '0;
        chk("drop_saturate", 32'(err_cnt), 32'd255);

        // Egress stall
        @(negedge clk);
        tx_ready   = 1'b0;
        psum_valid = 1'b1;
        psum_data  = 13'd23;
        @(negedge clk);
        psum_data = 13'd99;
        for (int j = 0; j < 3; j++) begin
            chk("stall_tx_valid", 32'(tx_valid), 32'(1));
            chk("stall_tx_pkt", tx_pkt, 32'h400D_4017);
            chk("stall_psum_ready", 32'(psum_ready), 32'(0));
            @(negedge clk);
        end
        psum_valid = 1'b0;
        tx_ready   = 1'b1;
        @(negedge clk);
        chk("stall_drained", 32'(tx_valid), 32'(0));

        // Full-rate burst
        beats = 0;
        for (int k = 0; k < 10; k++) begin
            psum_valid = 1'b1;
            psum_data  = 13'(100 + k);
            @(negedge clk);
            if (tx_valid) beats++;
            chk("burst_pkt", tx_pkt, 32'h400D_4000 | 32'(100 + k));
        end
        psum_valid = 1'b0;
        @(negedge clk);
        chk("burst_beats", 32'(beats), 32'd10);
        chk("burst_idle", 32'(tx_valid), 32'(0));

        // Reset mid-operation
        send(mk(2'b00, 5'd13, 3'd2, 8'h60, 13'd41));
        send(mk(2'b00, 5'd13, 3'd2, 8'h61, 13'd42));
        @(negedge clk);
        tx_ready   = 1'b0;
        psum_valid = 1'b1;
        psum_data  = 13'd5;
        @(negedge clk);
        psum_valid = 1'b0;
        chk("pre_rst_tx_valid", 32'(tx_valid), 32'(1));
        chk("pre_rst_filt_valid", 32'(filt_valid), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tx_valid", 32'(tx_valid), 32'(0));
        chk("midrst_filt_valid", 32'(filt_valid), 32'(0));
        chk("midrst_ifm_valid", 32'(ifm_valid), 32'(0));
        chk("midrst_err_cnt", 32'(err_cnt), 32'(0));
        chk("midrst_rx_ready", 32'(rx_ready), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(mk(2'b00, 5'd13, 3'd2, 8'h70, 13'd77));
        chk("after_rst_data", 32'(filt_data), 32'd77);
        chk("after_rst_src", 32'(filt_src), 32'h70);
        pop_filt();
        chk("after_rst_alone", 32'(filt_valid), 32'(0));
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
